param_sum_accumulator: RTL and testbench

//  Downstream consumer of the parameterised constant/sum submodule output.

---
 rtl/param_sum_accumulator.sv | 99 +++++++++
 tb/tb_param_sum_accumulator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_sum_accumulator.sv
// Burst accumulator: adds offset P to each accepted operand, sums NUM beats,
// then holds the total and a sticky wrap flag until the sink takes it.
//
//   state | meaning
//   IDLE  | waiting for the first beat of a burst
//   ACCUM | beats 2..NUM being summed
//   HOLD  | total presented on out_sum until out_ready
module param_sum_accumulator #(
  parameter int                 WIDTH = 32,
  parameter logic signed [31:0] P     = 32'sd1,
  parameter int                 NUM   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  // Offset sign-extended into the two guard bits; any guard bit set after the
  // add means the running sum left 0..2^WIDTH-1 (carry out or borrow).
  localparam logic [WIDTH+1:0] P_EXT   = {{(WIDTH-30){P[31]}}, P};
  localparam logic [7:0]       NUM_CNT = 8'(NUM);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic [WIDTH+1:0] sum_wide;
  logic             carry;
  logic             xfer_in;

  assign sum_wide = {2'b00, acc} + {2'b00, in_data} + P_EXT;
  assign carry    = |sum_wide[WIDTH+1:WIDTH];
  assign xfer_in  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        // acc is always zero here, so sum_wide is just the addend
        if (xfer_in) begin
          acc_nxt   = sum_wide[WIDTH-1:0];
          cnt_nxt   = 8'd1;
          ovf_nxt   = carry;
          state_nxt = (NUM_CNT == 8'd1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer_in) begin
          acc_nxt = sum_wide[WIDTH-1:0];
          cnt_nxt = cnt + 8'd1;
          ovf_nxt = ovf | carry;
          if (cnt + 8'd1 == NUM_CNT) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = rst_n && (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_sum   = (state == HOLD) ? acc : '0;
  assign out_ovf   = (state == HOLD) && ovf;
  assign busy      = (state == ACCUM) || (state == HOLD);

endmodule

// File: tb/tb_param_sum_accumulator.sv
// Scoreboard bench: three accumulator configurations driven with directed and
// random bursts, checked against a plain-arithmetic burst model.
module tb_param_sum_accumulator;

  localparam int     NI          = 3;
  localparam int     NUM_A[NI]   = '{4, 1, 3};
  localparam longint P_A[NI]     = '{1, 1, -3};
  localparam longint MAX_U32     = 64'sd4294967295;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid[NI];
  logic        in_ready[NI];
  logic [31:0] in_data[NI];
  logic        out_valid[NI];
  logic        out_ready[NI];
  logic [31:0] out_sum[NI];
  logic        out_ovf[NI];
  logic        busy[NI];

  int n_checks = 0;
  int n_pass = 0;

  longint      m_acc[NI];
  int          m_cnt[NI];
  bit          m_ovf[NI];
  logic [32:0] exp_q[NI][$];

  bit          rand_sink = 1'b0;
  bit          prev_hold[NI];
  logic [31:0] prev_sum[NI];
  logic [32:0] e_mon;

  always #5 clk = ~clk;

  param_sum_accumulator #(.WIDTH(32), .P(32'sd1), .NUM(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(out_sum[0]), .out_ovf(out_ovf[0]), .busy(busy[0]));

  param_sum_accumulator #(.WIDTH(32), .P(32'sd1), .NUM(1)) u_dut_one (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(out_sum[1]), .out_ovf(out_ovf[1]), .busy(busy[1]));

  param_sum_accumulator #(.WIDTH(32), .P(-32'sd3), .NUM(3)) u_dut_neg (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_sum(out_sum[2]), .out_ovf(out_ovf[2]), .busy(busy[2]));

  function automatic void check(string name, int u, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (dut %0d): got %0h, expected %0h", name, u, act, exp);
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < NI; u++) begin
      m_acc[u] = 0;
      m_cnt[u] = 0;
      m_ovf[u] = 1'b0;
    end
  endfunction

  // True integer sum; leaving the unsigned 32-bit range at any beat marks the burst.
  function automatic void model_beat(int u, logic [31:0] d);
    longint t;
    t = m_acc[u] + longint'({32'b0, d}) + P_A[u];
    if (t < 0 || t > MAX_U32) m_ovf[u] = 1'b1;
    m_acc[u] = t & 64'hFFFF_FFFF;
    m_cnt[u]++;
    if (m_cnt[u] == NUM_A[u]) begin
      exp_q[u].push_back({m_ovf[u], m_acc[u][31:0]});
      m_acc[u] = 0;
      m_cnt[u] = 0;
      m_ovf[u] = 1'b0;
    end
  endfunction

  task automatic send(int u, logic [31:0] d);
    int guard;
    @(negedge clk);
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    guard = 0;
    while (!in_ready[u] && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      n_checks++;
      $display("FAIL send_timeout (dut %0d): in_ready stayed 0, expected 1", u);
      in_valid[u] = 1'b0;
      return;
    end
    model_beat(u, d);
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_run(int u, int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0: d = $urandom_range(0, 100);
        1: d = 32'hFFFF_FFFF - $urandom_range(0, 3);
        2: d = $urandom;
        default: d = $urandom_range(0, 3);
      endcase
      send(u, d);
      repeat ($urandom_range(0, 2)) cycle();
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_sink)
      for (int u = 0; u < NI; u++) out_ready[u] = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    for (int u = 0; u < NI; u++) begin
      if (prev_hold[u]) begin
        check("hold_valid_stable", u, {31'b0, out_valid[u]}, 32'd1);
        check("hold_sum_stable", u, out_sum[u], prev_sum[u]);
      end
      if (!out_valid[u]) check("idle_sum_zero", u, out_sum[u], 32'd0);
      if (rst_n && out_valid[u] && out_ready[u]) begin
        if (exp_q[u].size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output (dut %0d): got sum %0h, expected no output", u, out_sum[u]);
        end else begin
          e_mon = exp_q[u].pop_front();
          check("out_sum", u, out_sum[u], e_mon[31:0]);
          check("out_ovf", u, {31'b0, out_ovf[u]}, {31'b0, e_mon[32]});
        end
      end
      prev_hold[u] = rst_n && out_valid[u] && !out_ready[u];
      prev_sum[u]  = out_sum[u];
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < NI; u++) begin
      in_valid[u]  = 1'b0;
      in_data[u]   = '0;
      out_ready[u] = 1'b1;
      prev_hold[u] = 1'b0;
      prev_sum[u]  = '0;
    end
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 0, {31'b0, in_ready[0]}, 32'd0);
    check("rst_out_valid", 0, {31'b0, out_valid[0]}, 32'd0);
    check("rst_out_sum", 0, out_sum[0], 32'd0);
    check("rst_out_ovf", 0, {31'b0, out_ovf[0]}, 32'd0);
    check("rst_busy", 0, {31'b0, busy[0]}, 32'd0);
    cycle();
    rst_n = 1'b1;

    // back-to-back burst of 3s: 4*(3+1)
    repeat (3) send(0, 32'd3);
    check("t1_no_early_valid", 0, {31'b0, out_valid[0]}, 32'd0);
    check("t1_busy", 0, {31'b0, busy[0]}, 32'd1);
    send(0, 32'd3);
    check("t1_valid", 0, {31'b0, out_valid[0]}, 32'd1);
    check("t1_in_ready_low", 0, {31'b0, in_ready[0]}, 32'd0);
    check("t1_sum", 0, out_sum[0], 32'd16);
    cycle();
    check("t1_back_idle", 0, {31'b0, in_ready[0]}, 32'd1);

    // sink stall: total must stay put
    out_ready[0] = 1'b0;
    repeat (4) send(0, 32'd3);
    repeat (6) begin
      cycle();
      check("t2_stall_valid", 0, {31'b0, out_valid[0]}, 32'd1);
      check("t2_stall_ready", 0, {31'b0, in_ready[0]}, 32'd0);
      check("t2_stall_sum", 0, out_sum[0], 32'd16);
    end
    out_ready[0] = 1'b1;
    cycle();
    check("t2_idle_valid", 0, {31'b0, out_valid[0]}, 32'd0);
    check("t2_idle_busy", 0, {31'b0, busy[0]}, 32'd0);
    check("t2_idle_ready", 0, {31'b0, in_ready[0]}, 32'd1);
    repeat (4) send(0, 32'd3);
    cycle();

    // gapped source
    for (int k = 1; k <= 4; k++) begin
      send(0, 32'(10 * k));
      cycle();
    end
    repeat (2) cycle();

    // wrap: every addend is exactly 2^32
    repeat (3) send(0, 32'hFFFF_FFFF);
    send(0, 32'hFFFF_FFFF);
    check("t4_wrap_sum", 0, out_sum[0], 32'd0);
    check("t4_wrap_ovf", 0, {31'b0, out_ovf[0]}, 32'd1);
    repeat (4) send(0, 32'd3);
    check("t4_clean_sum", 0, out_sum[0], 32'd16);
    check("t4_clean_ovf", 0, {31'b0, out_ovf[0]}, 32'd0);
    cycle();

    // reset mid-burst
    repeat (2) send(0, 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_in_ready", 0, {31'b0, in_ready[0]}, 32'd0);
    cycle();
    check("t5_rst_busy", 0, {31'b0, busy[0]}, 32'd0);
    rst_n = 1'b1;
    model_reset();
    repeat (4) send(0, 32'd3);
    cycle();

    // single-beat bursts
    send(1, 32'd7);
    check("t6_valid", 1, {31'b0, out_valid[1]}, 32'd1);
    check("t6_in_ready_low", 1, {31'b0, in_ready[1]}, 32'd0);
    check("t6_sum", 1, out_sum[1], 32'd8);
    cycle();
    check("t6_in_ready_back", 1, {31'b0, in_ready[1]}, 32'd1);
    check("t6_valid_clear", 1, {31'b0, out_valid[1]}, 32'd0);

    // random traffic with a randomly stalling sink
    rand_sink = 1'b1;
    fork
      rand_run(0, 120);
      rand_run(1, 60);
      rand_run(2, 120);
    join
    rand_sink = 1'b0;
    cycle();
    for (int u = 0; u < NI; u++) out_ready[u] = 1'b1;
    repeat (10) cycle();
    for (int u = 0; u < NI; u++) check("drain_empty", u, 32'(exp_q[u].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
